// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two valid/ready requesters share one external registered 8-bit shifter.
// Build option SHIFTER_ARB_FIXED_PRIO_EN selects strict channel-0 priority instead of round-robin.
module shifter_arbiter #(
  parameter int W  = 8,
  parameter int NW = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [1:0]    REQ_VALID,
  output logic [1:0]    REQ_READY,
  input  logic [W-1:0]  REQ_DATA0,
  input  logic [W-1:0]  REQ_DATA1,
  input  logic [NW-1:0] REQ_N0,
  input  logic [NW-1:0] REQ_N1,
  input  logic          REQ_DIR0,
  input  logic          REQ_DIR1,
  output logic [W-1:0]  SH_DATA_IN,
  output logic [NW-1:0] SH_N,
  output logic          SH_DIR,
  input  logic [W-1:0]  SH_DATA_OUT,
  output logic [1:0]    RSP_VALID,
  input  logic [1:0]    RSP_READY,
  output logic [W-1:0]  RSP_DATA,
  output logic          BUSY,
  output logic [1:0]    DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   gnt_q;
  logic   pick;
  logic   accept;
  logic   rsp_done;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
  logic   lg_q;
`endif

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
  // Requests are ready only in IDLE; a response stays valid until the granted channel's ready.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
    pick = ~REQ_VALID[0];
`else
    pick = (REQ_VALID == 2'b11) ? ~lg_q : REQ_VALID[1];
`endif
    state_d   = state_q;
    REQ_READY = 2'b00;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!Reset && (REQ_VALID != 2'b00)) begin
          REQ_READY = 2'b01 << pick;
          accept    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP: begin
        if (RSP_READY[gnt_q]) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands stay on SH_* until the next accept; the shifter output is valid during WAIT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SH_DATA_IN <= '0;
      SH_N       <= '0;
      SH_DIR     <= 1'b0;
      gnt_q      <= 1'b0;
      RSP_VALID  <= 2'b00;
      RSP_DATA   <= '0;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
      lg_q       <= 1'b1;
`endif
    end else begin
      if (accept) begin
        SH_DATA_IN <= pick ? REQ_DATA1 : REQ_DATA0;
        SH_N       <= pick ? REQ_N1 : REQ_N0;
        SH_DIR     <= pick ? REQ_DIR1 : REQ_DIR0;
        gnt_q      <= pick;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
        lg_q       <= pick;
`endif
      end
      if (state_q == ST_WAIT) begin
        RSP_DATA  <= SH_DATA_OUT;
        RSP_VALID <= 2'b01 << gnt_q;
      end else if (rsp_done) begin
        RSP_VALID <= 2'b00;
      end
    end
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule
